host_bus_ctrl: RTL and testbench
================================

Name: host_bus_ctrl

Overview:
- Host-bus access controller for the FPGA display controller; sits directly upstream of the bidirectional data-bus pin block and drives its outToBus/outputEnable and consumes its inFromBus.
- Synchronizes the asynchronous host strobes, deglitches chip select, and sequences the 74LVC245 direction/enable so that neither side contends.
- Converts each host access into exactly one internal register-write pulse or one register-read pulse.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers for hostCsN, hostRnw, hostAddr and inFromBus (all the same depth).
- MIN_CS_CYCLES, 2, consecutive synced-low samples of hostCsN needed before an access is accepted (deglitch).
- ADDR_WIDTH, 2, width of the host register address.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- hostCsN  in  1  host chip select, active-low, asynchronous.
- hostRnw  in  1  host read/not-write, asynchronous.
- hostAddr  in  ADDR_WIDTH  host register select, asynchronous.
- inFromBus  in  8  byte read from the data pins.
- outToBus  out  8  byte driven to the data pins.
- outputEnable  out  1  1 = FPGA drives the data pins.
- xcvrDir  out  1  transceiver direction; 1 = FPGA to host, 0 = host to FPGA.
- xcvrOeN  out  1  transceiver enable, active-low.
- regAddr  out  ADDR_WIDTH  latched register address of the current access.
- regWrData  out  8  captured write byte; valid while regWrEn = 1.
- regWrEn  out  1  one-cycle write pulse.
- regRdEn  out  1  one-cycle read pulse (lets the register consumer apply read side effects).
- regRdData  in  8  read data; the block samples it 1 cycle after regRdEn.

Behaviour:
- Reset values (state IDLE, outputs at the next edge with rst = 1):
  - outToBus = 0, outputEnable = 0, xcvrDir = 0, xcvrOeN = 1.
  - regAddr = 0, regWrData = 0, regWrEn = 0, regRdEn = 0.
  - Synchronizer flops reset to 1 for hostCsN and to 0 for all other inputs.
- Synchronization: csS, rnwS, addrS and dataS are the SYNC_STAGES-delayed copies of the inputs. All decisions use only these copies.
- Deglitch:
  - In IDLE, a counter increments each cycle csS = 0 and clears when csS = 1.
  - When csS = 0 and count = MIN_CS_CYCLES-1, the access is accepted: regAddr <= addrS, and the next state is chosen by rnwS.
  - A shorter low pulse produces no access and no change to any output.
- IDLE: no drive; xcvrOeN = 1, xcvrDir = 0.
- READ_SETUP (1 cycle):
  - xcvrDir = 1, regRdEn = 1, xcvrOeN = 1, outputEnable = 0.
  - At the end of the cycle, outToBus <= regRdData.
  - Next state is READ_DRIVE if csS = 0, else TURNAROUND. The read side effect still counts as consumed in the TURNAROUND case.
- READ_DRIVE:
  - outputEnable = 1, xcvrOeN = 0, xcvrDir = 1.
  - outToBus is held stable for the whole state.
  - Leave to TURNAROUND when csS = 1.
- WRITE_WAIT:
  - xcvrDir = 0, xcvrOeN = 0, outputEnable = 0.
  - Each cycle with csS = 0, the write shadow register <= dataS. The captured byte is therefore the one sampled at the last edge where hostCsN was sampled low.
  - When csS = 1: go to TURNAROUND, with regWrEn = 1 and regWrData = shadow during the TURNAROUND cycle.
- TURNAROUND (1 cycle):
  - outputEnable = 0, xcvrOeN = 1.
  - xcvrDir keeps its previous value, then returns to 0 on entry to IDLE.
  - Next state is IDLE.
- Ordering invariants (must hold every cycle):
  - outputEnable = 1 implies xcvrDir = 1, and xcvrDir has been 1 for at least 1 prior cycle.
  - xcvrDir falls only after outputEnable has been 0 for at least 1 cycle.
- Latency with default parameters, counted from the first edge that samples hostCsN low:
  - regRdEn is high in the cycle after edge 4.
  - outputEnable is high after edge 5.
  - Write: regWrEn is high in the cycle after the 3rd edge that samples hostCsN high.
- Exactly one regWrEn or regRdEn pulse per accepted access.
- Back-to-back accesses: a new access is accepted only from IDLE, which is reached only via TURNAROUND after csS = 1, so one host access can never produce two pulses.
- Reset mid-access: at the next edge with rst = 1, the bus is released (outputEnable = 0, xcvrOeN = 1, xcvrDir = 0), no pulse is emitted, and the state is IDLE.

Test Plan:
- Reset: hold rst for 3 cycles with hostCsN = 0 -> all outputs at their reset values; no access starts until csS has been high and then low for 2 samples.
- Write: addr = 2, data = 0xA5, CS low for 8 cycles, data changed to 0x5A while CS rises -> exactly one regWrEn pulse, regAddr = 2, regWrData = 0xA5.
- Read: addr = 1, rnw = 1, regRdData = 0x3C, CS low for 10 cycles -> one regRdEn pulse; outputEnable high from edge 5; outToBus = 0x3C; ordering invariants hold on rise and fall.
- Glitch: CS low for exactly 1 cycle -> no pulses; xcvrOeN stays 1.
- Abort: read with CS released during READ_SETUP -> regRdEn = 1 once, outputEnable never 1, returns to IDLE via TURNAROUND.
- Reset mid-read: assert rst in READ_DRIVE -> outputEnable = 0, xcvrOeN = 1, xcvrDir = 0 after 1 edge; a following write of 0x11 to addr 0 completes normally.

Source files
------------

// File: rtl/host_bus_ctrl.sv
// Host-bus access controller: synchronizes asynchronous host strobes and turns each host
// access into a single register read or write pulse. It also sequences the 74LVC245 so the bus never contends.
module host_bus_ctrl #(
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_CS_CYCLES = 2,
   parameter int ADDR_WIDTH    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hostCsN,
   input  logic                  hostRnw,
   input  logic [ADDR_WIDTH-1:0] hostAddr,
   input  logic [7:0]            inFromBus,
   output logic [7:0]            outToBus,
   output logic                  outputEnable,
   output logic                  xcvrDir,
   output logic                  xcvrOeN,
   output logic [ADDR_WIDTH-1:0] regAddr,
   output logic [7:0]            regWrData,
   output logic                  regWrEn,
   output logic                  regRdEn,
   input  logic [7:0]            regRdData
);

   localparam int CNT_W = $clog2(MIN_CS_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_CS_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ_SETUP,
      READ_DRIVE,
      WRITE_WAIT,
      TURNAROUND
   } busState_t;

   busState_t state, stateNext;

   logic                  csSync   [SYNC_STAGES];
   logic                  rnwSync  [SYNC_STAGES];
   logic [ADDR_WIDTH-1:0] addrSync [SYNC_STAGES];
   logic [7:0]            dataSync [SYNC_STAGES];

   logic                  csS;
   logic                  rnwS;
   logic [ADDR_WIDTH-1:0] addrS;
   logic [7:0]            dataS;
   logic [CNT_W-1:0]      csCount;
   logic                  accept;
   logic                  dirHold;

   // Synchronizer stage boundary: every decision below uses only the *S copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            csSync[i]   <= 1'b1;
            rnwSync[i]  <= 1'b0;
            addrSync[i] <= '0;
            dataSync[i] <= '0;
         end
      end else begin
         csSync[0]   <= hostCsN;
         rnwSync[0]  <= hostRnw;
         addrSync[0] <= hostAddr;
         dataSync[0] <= inFromBus;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            csSync[i]   <= csSync[i-1];
            rnwSync[i]  <= rnwSync[i-1];
            addrSync[i] <= addrSync[i-1];
            dataSync[i] <= dataSync[i-1];
         end
      end
   end

   assign csS   = csSync[SYNC_STAGES-1];
   assign rnwS  = rnwSync[SYNC_STAGES-1];
   assign addrS = addrSync[SYNC_STAGES-1];
   assign dataS = dataSync[SYNC_STAGES-1];

   assign accept = (state == IDLE) && !csS && (csCount == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst || (state != IDLE) || csS || accept) begin
         csCount <= '0;
      end else begin
         csCount <= csCount + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dirHold <= 1'b0;
      end else begin
         state   <= stateNext;
         dirHold <= xcvrDir;
      end
   end

   always_comb begin
      stateNext    = state;
      outputEnable = 1'b0;
      xcvrOeN      = 1'b1;
      xcvrDir      = 1'b0;
      regRdEn      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) stateNext = rnwS ? READ_SETUP : WRITE_WAIT;
         end
         READ_SETUP: begin
            xcvrDir   = 1'b1;
            regRdEn   = 1'b1;
            stateNext = csS ? TURNAROUND : READ_DRIVE;
         end
         READ_DRIVE: begin
            outputEnable = 1'b1;
            xcvrOeN      = 1'b0;
            xcvrDir      = 1'b1;
            if (csS) stateNext = TURNAROUND;
         end
         WRITE_WAIT: begin
            xcvrOeN = 1'b0;
            if (csS) stateNext = TURNAROUND;
         end
         TURNAROUND: begin
            // Direction lingers one cycle after the drivers are off, so it never flips under drive.
            xcvrDir   = dirHold;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Capture the accepting sample as well, so a minimum-length write still latches its byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         outToBus  <= '0;
         regAddr   <= '0;
         regWrData <= '0;
         regWrEn   <= 1'b0;
      end else begin
         regWrEn <= (state == WRITE_WAIT) && csS;
         if (accept) regAddr <= addrS;
         if (state == READ_SETUP) outToBus <= regRdData;
         if ((accept && !rnwS) || ((state == WRITE_WAIT) && !csS)) regWrData <= dataS;
      end
   end

endmodule

// File: tb/tb_host_bus_ctrl.sv
// Self-checking bench for host_bus_ctrl: directed scenarios plus randomized accesses,
// predicted from the access-level timing rules rather than from the controller's states.
module tb_host_bus_ctrl;

   localparam int SYNC  = 2;
   localparam int MINCS = 2;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       hostCsN   = 1'b0;
   logic       hostRnw   = 1'b1;
   logic [1:0] hostAddr  = 2'd0;
   logic [7:0] inFromBus = 8'h00;
   logic [7:0] regRdData = 8'h00;
   logic [7:0] outToBus;
   logic       outputEnable, xcvrDir, xcvrOeN, regWrEn, regRdEn;
   logic [1:0] regAddr;
   logic [7:0] regWrData;

   host_bus_ctrl #(.SYNC_STAGES(SYNC), .MIN_CS_CYCLES(MINCS), .ADDR_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .hostCsN(hostCsN), .hostRnw(hostRnw), .hostAddr(hostAddr),
      .inFromBus(inFromBus), .outToBus(outToBus), .outputEnable(outputEnable),
      .xcvrDir(xcvrDir), .xcvrOeN(xcvrOeN), .regAddr(regAddr), .regWrData(regWrData),
      .regWrEn(regWrEn), .regRdEn(regRdEn), .regRdData(regRdData)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Per-access observation record
   int         cyc, rdCnt, wrCnt, rdFirst, wrCyc, oeCnt, oeFirst, oeNLow, driveBad, invViol;
   logic [1:0] rdAddr, wrAddr;
   logic [7:0] wrData, expDrive;
   logic       prevDir = 1'b0;
   logic       prevOe  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearRec();
      cyc = 0; rdCnt = 0; wrCnt = 0; rdFirst = -1; wrCyc = -1; oeCnt = 0; oeFirst = -1;
      oeNLow = 0; driveBad = 0; invViol = 0;
      rdAddr = '0; wrAddr = '0; wrData = '0;
   endtask

   // Advance one clock and observe the outputs 1 time unit after the edge.
   task automatic step();
      logic rstEdge;
      rstEdge = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (regRdEn) begin
         rdCnt++;
         if (rdFirst < 0) rdFirst = cyc;
         rdAddr = regAddr;
      end
      if (regWrEn) begin
         wrCnt++;
         wrCyc  = cyc;
         wrAddr = regAddr;
         wrData = regWrData;
      end
      if (outputEnable) begin
         oeCnt++;
         if (oeFirst < 0) oeFirst = cyc;
         if (outToBus !== expDrive) driveBad++;
      end
      if (!xcvrOeN) oeNLow++;
      if (!rstEdge) begin
         if (outputEnable && !(xcvrDir && prevDir)) invViol++;
         if (outputEnable && xcvrOeN) invViol++;
         if (prevDir && !xcvrDir && prevOe) invViol++;
         if (regWrEn && regRdEn) invViol++;
      end
      prevDir = xcvrDir;
      prevOe  = outputEnable;
   endtask

   // One host access: CS low for lowLen clocks, then released with the data/address
   // lines changing at the same moment, followed by an idle gap.
   task automatic access(input string tag, input logic rnw, input logic [1:0] addr,
                         input logic [7:0] data, input logic [7:0] rd, input int lowLen);
      bit acc;
      int expOe;
      hostAddr  = addr;
      hostRnw   = rnw;
      inFromBus = data;
      regRdData = rd;
      expDrive  = rd;
      clearRec();
      hostCsN = 1'b0;
      for (int i = 0; i < lowLen; i++) begin
         step();
         if (cyc == SYNC + MINCS + 1) regRdData = ~rd;
      end
      hostCsN   = 1'b1;
      inFromBus = ~data;
      hostAddr  = ~addr;
      repeat (8) step();

      acc   = (lowLen >= MINCS);
      expOe = (rnw && lowLen > MINCS) ? lowLen - MINCS : 0;
      check({tag, ".rdPulses"}, rdCnt, (rnw && acc) ? 1 : 0);
      check({tag, ".wrPulses"}, wrCnt, (!rnw && acc) ? 1 : 0);
      check({tag, ".oeCycles"}, oeCnt, expOe);
      check({tag, ".ordering"}, invViol, 0);
      if (!acc) check({tag, ".xcvrOeNLow"}, oeNLow, 0);
      if (rnw && acc) begin
         check({tag, ".rdEnCycle"}, rdFirst, SYNC + MINCS);
         check({tag, ".rdAddr"}, rdAddr, addr);
      end
      if (expOe > 0) begin
         check({tag, ".oeFirst"}, oeFirst, SYNC + MINCS + 1);
         check({tag, ".driveBad"}, driveBad, 0);
      end
      if (!rnw && acc) begin
         check({tag, ".wrEnCycle"}, wrCyc, lowLen + SYNC + 1);
         check({tag, ".wrAddr"}, wrAddr, addr);
         check({tag, ".wrData"}, wrData, data);
      end
      check({tag, ".idleBus"}, {outputEnable, xcvrOeN, xcvrDir}, 3'b010);
   endtask

   initial begin
      logic [7:0] rdv;
      clearRec();
      expDrive  = 8'h00;
      regRdData = 8'h77;

      // Reset held with CS low: all outputs at reset values.
      repeat (3) step();
      check("rst.outToBus", outToBus, 8'h00);
      check("rst.bus", {outputEnable, xcvrDir, xcvrOeN}, 3'b001);
      check("rst.regAddr", regAddr, 2'd0);
      check("rst.regWrData", regWrData, 8'h00);
      check("rst.pulses", {regWrEn, regRdEn}, 2'b00);

      // CS still low after release: the access waits for full synchronization + deglitch.
      rst      = 1'b0;
      expDrive = 8'h77;
      clearRec();
      repeat (SYNC + MINCS - 1) step();
      check("rst.noEarlyAccess", rdCnt + oeNLow, 0);
      step();
      check("rst.firstRdEn", regRdEn, 1'b1);
      hostCsN = 1'b1;
      repeat (8) step();
      check("rst.onePulse", rdCnt, 1);

      // Directed scenarios.
      access("write", 1'b0, 2'd2, 8'hA5, 8'h00, 8);
      access("read", 1'b1, 2'd1, 8'h00, 8'h3C, 10);
      access("glitchW", 1'b0, 2'd3, 8'hFF, 8'h00, 1);
      access("glitchR", 1'b1, 2'd3, 8'h00, 8'hEE, 1);
      access("abort", 1'b1, 2'd2, 8'h00, 8'h96, 2);
      access("minWrite", 1'b0, 2'd1, 8'h4B, 8'h00, 2);

      // Reset while the FPGA drives the bus.
      hostAddr  = 2'd3;
      hostRnw   = 1'b1;
      regRdData = 8'hC3;
      expDrive  = 8'hC3;
      clearRec();
      hostCsN = 1'b0;
      repeat (SYNC + MINCS + 3) step();
      check("midRst.driving", outputEnable, 1'b1);
      rst = 1'b1;
      step();
      check("midRst.bus", {outputEnable, xcvrOeN, xcvrDir}, 3'b010);
      check("midRst.pulses", {regWrEn, regRdEn}, 2'b00);
      rst     = 1'b0;
      hostCsN = 1'b1;
      repeat (8) step();
      check("midRst.rdPulses", rdCnt, 1);
      check("midRst.wrPulses", wrCnt, 0);
      check("midRst.ordering", invViol, 0);
      access("postRstWrite", 1'b0, 2'd0, 8'h11, 8'h00, 5);

      // Randomized accesses.
      for (int n = 0; n < 24; n++) begin
         rdv = 8'($urandom_range(0, 255));
         access($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), rdv, int'($urandom_range(1, 12)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
